// File: rtl/bpsk_demod.sv
`default_nettype none
// ============================================================================
// Module      : bpsk_demod
// Description : Coherent BPSK receiver. It multiplies the received sample by the
//               local carrier, integrates the product over one symbol and
//               slices the sign of the result.
// Revision    : 1.0 - initial release
// ============================================================================
module bpsk_demod #(
   parameter int               DWIDTH = 16,
   parameter int               CWIDTH = 16,
   parameter int               SPS    = 1280,
   parameter int               ACC_W  = 48,
   parameter logic [ACC_W-1:0] THRESH = '0
) (
   input  logic                     clk_sig,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic signed [DWIDTH-1:0] rx_sig,
   input  logic signed [CWIDTH-1:0] carrier_sig,
   input  logic                     sym_sync,
   output logic                     bit_sig,
   output logic                     bit_valid,
   output logic signed [ACC_W-1:0]  soft_sig,
   output logic                     erase_sig
);

   localparam int                 c_PW    = DWIDTH + CWIDTH;
   localparam int                 c_CNT_W = $clog2(SPS);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(SPS - 1);

   logic signed [c_PW-1:0]  w_rx_ext;
   logic signed [c_PW-1:0]  w_car_ext;
   logic signed [c_PW-1:0]  w_prod;
   logic signed [ACC_W-1:0] w_prod_ext;
   logic signed [ACC_W-1:0] w_sum;
   logic signed [ACC_W-1:0] w_neg;
   logic        [ACC_W-1:0] w_abs;
   logic                    w_erase;
   logic                    w_bit;

   logic signed [c_PW-1:0]  r_prod;
   logic                    r_prod_v;
   logic                    r_sync;
   logic signed [ACC_W-1:0] r_acc;
   logic [c_CNT_W-1:0]      r_cnt;

   // Operands are widened first so the product keeps all DWIDTH+CWIDTH bits.
   assign w_rx_ext   = c_PW'(rx_sig);
   assign w_car_ext  = c_PW'(carrier_sig);
   assign w_prod     = w_rx_ext * w_car_ext;
   assign w_prod_ext = ACC_W'(r_prod);
   assign w_sum      = r_acc + w_prod_ext;
   assign w_neg      = -w_sum;
   assign w_abs      = w_sum[ACC_W-1] ? w_neg : w_sum;
   assign w_erase    = (w_abs <= THRESH);
   // A zero integral decides 0.
   assign w_bit      = !w_sum[ACC_W-1] && (w_sum != '0);

   always_ff @(posedge clk_sig) begin
      if (!rst_n) begin
         r_prod   <= '0;
         r_prod_v <= 1'b0;
         r_sync   <= 1'b0;
      end else begin
         if (in_valid) begin
            r_prod <= w_prod;
         end
         r_prod_v <= in_valid;
         r_sync   <= sym_sync & in_valid;
      end
   end

   always_ff @(posedge clk_sig) begin
      if (!rst_n) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         bit_sig   <= 1'b0;
         bit_valid <= 1'b0;
         soft_sig  <= '0;
         erase_sig <= 1'b0;
      end else begin
         bit_valid <= 1'b0;
         if (r_prod_v) begin
            if (r_sync) begin
               r_acc <= w_prod_ext;
               r_cnt <= c_CNT_W'(1);
            end else if (r_cnt == c_LAST) begin
               soft_sig  <= w_sum;
               bit_sig   <= w_bit;
               erase_sig <= w_erase;
               bit_valid <= 1'b1;
               r_acc     <= '0;
               r_cnt     <= '0;
            end else begin
               r_acc <= w_sum;
               r_cnt <= r_cnt + c_CNT_W'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bpsk_demod.sv
`default_nettype none
// ============================================================================
// Module      : tb_bpsk_demod
// Description : Self-checking bench for bpsk_demod with SPS=8 and a
//               symbol-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bpsk_demod;

   localparam int SPS    = 8;
   localparam int ACC_W  = 48;
   localparam longint THRESH = 0;

   logic                    clk_sig = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    in_valid = 1'b0;
   logic signed [15:0]      rx_sig = '0;
   logic signed [15:0]      carrier_sig = '0;
   logic                    sym_sync = 1'b0;
   logic                    bit_sig;
   logic                    bit_valid;
   logic signed [ACC_W-1:0] soft_sig;
   logic                    erase_sig;

   bpsk_demod #(
      .DWIDTH (16),
      .CWIDTH (16),
      .SPS    (SPS),
      .ACC_W  (ACC_W),
      .THRESH (48'd0)
   ) dut (
      .clk_sig     (clk_sig),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .rx_sig      (rx_sig),
      .carrier_sig (carrier_sig),
      .sym_sync    (sym_sync),
      .bit_sig     (bit_sig),
      .bit_valid   (bit_valid),
      .soft_sig    (soft_sig),
      .erase_sig   (erase_sig)
   );

   always #5 clk_sig = ~clk_sig;

   int checks = 0;
   int errors = 0;

   // Model: products of the symbol currently being collected, plus a one-edge
   // pending result for the dump that the DUT shows after the following edge.
   longint q[$];
   bit     pend_v = 0;
   longint pend_sum = 0;
   bit     exp_valid = 0;
   bit     exp_bit = 0;
   bit     exp_erase = 0;
   longint exp_soft = 0;

   typedef struct {
      logic signed [15:0] rx;
      logic signed [15:0] car;
      logic               bit_e;
      longint             soft_e;
      logic               erase_e;
   } vec_t;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic logic signed [63:0] soft64();
      return {{(64-ACC_W){soft_sig[ACC_W-1]}}, soft_sig};
   endfunction

   task automatic step(input logic v, input logic signed [15:0] rx, input logic signed [15:0] car,
                       input logic sy, input logic rn);
      longint p, s, a;
      in_valid = v; rx_sig = rx; carrier_sig = car; sym_sync = sy; rst_n = rn;
      @(posedge clk_sig);
      #1;
      if (!rn) begin
         q.delete();
         pend_v = 0;
         exp_valid = 0; exp_bit = 0; exp_erase = 0; exp_soft = 0;
      end else begin
         exp_valid = pend_v;
         if (pend_v) begin
            exp_soft  = pend_sum;
            exp_bit   = (pend_sum > 0);
            a         = (pend_sum < 0) ? -pend_sum : pend_sum;
            exp_erase = (a <= THRESH);
         end
         pend_v = 0;
         if (v) begin
            p = longint'(rx) * longint'(car);
            if (sy) begin
               q.delete();
               q.push_back(p);
            end else if (q.size() == SPS - 1) begin
               s = p;
               foreach (q[i]) s += q[i];
               pend_sum = s;
               pend_v = 1;
               q.delete();
            end else begin
               q.push_back(p);
            end
         end
      end
      chk("model_valid", 64'(bit_valid), 64'(exp_valid));
      chk("model_soft", soft64(), exp_soft);
      if (exp_valid || !rn) begin
         chk("model_bit", 64'(bit_sig), 64'(exp_bit));
         chk("model_erase", 64'(erase_sig), 64'(exp_erase));
      end
   endtask

   task automatic symbol(input logic signed [15:0] rx, input logic signed [15:0] car);
      for (int i = 0; i < SPS; i++) step(1'b1, rx, car, 1'b0, 1'b1);
   endtask

   vec_t tbl[6];
   int   n;

   initial begin
      tbl[0] = '{16'sh7FFF, 16'sh7FFF, 1'b1,  64'sh1_FFF8_0008, 1'b0};
      tbl[1] = '{16'sh8000, 16'sh7FFF, 1'b0, -64'sh1_FFFC_0000, 1'b0};
      tbl[2] = '{16'sh8000, 16'sh8000, 1'b1,  64'sh2_0000_0000, 1'b0};
      tbl[3] = '{16'sh0000, 16'sh7FFF, 1'b0,  64'sh0,           1'b1};
      tbl[4] = '{16'sh0001, 16'shFFFF, 1'b0, -64'sd8,           1'b0};
      tbl[5] = '{16'sh0001, 16'sh0001, 1'b1,  64'sd8,           1'b0};

      // Reset state
      step(1'b1, 16'sh7FFF, 16'sh7FFF, 1'b1, 1'b0);
      step(1'b0, 16'sh0, 16'sh0, 1'b0, 1'b0);
      chk("rst_valid", 64'(bit_valid), 64'd0);
      chk("rst_soft", soft64(), 64'd0);
      chk("rst_bit", 64'(bit_sig), 64'd0);
      chk("rst_erase", 64'(erase_sig), 64'd0);

      // One full symbol per table row, then one gap edge to see the dump
      foreach (tbl[r]) begin
         symbol(tbl[r].rx, tbl[r].car);
         step(1'b0, 16'sh0, 16'sh0, 1'b0, 1'b1);
         chk("tbl_valid", 64'(bit_valid), 64'd1);
         chk("tbl_bit", 64'(bit_sig), 64'(tbl[r].bit_e));
         chk("tbl_soft", soft64(), tbl[r].soft_e);
         chk("tbl_erase", 64'(erase_sig), 64'(tbl[r].erase_e));
      end

      // Back-to-back symbols: dump of one and first sample of the next share an edge
      for (int s = 0; s < 4; s++) symbol(16'sh7FFF, 16'sh7FFF);
      step(1'b0, 16'sh0, 16'sh0, 1'b0, 1'b1);

      // in_valid toggling every other cycle
      for (int i = 0; i < 4 * SPS; i++) begin
         step(1'b1, 16'sh7FFF, 16'sh7FFF, 1'b0, 1'b1);
         step(1'b0, 16'sh1234, 16'sh1234, 1'b1, 1'b1);
      end
      step(1'b0, 16'sh0, 16'sh0, 1'b0, 1'b1);

      // sym_sync on valid sample 5: no dump for the partial, next dump 8 edges later
      for (int i = 0; i < 5; i++) step(1'b1, 16'sh4000, 16'sh4000, 1'b0, 1'b1);
      step(1'b1, 16'sh0100, 16'sh0100, 1'b1, 1'b1);
      n = 0;
      do begin
         step(1'b1, 16'sh0100, 16'sh0100, 1'b0, 1'b1);
         n++;
      end while (!bit_valid && n < 20);
      chk("sync_latency", 64'(n), 64'd8);

      // sym_sync on what would be the last sample: sync wins
      for (int i = 0; i < SPS - 1; i++) step(1'b1, 16'sh0100, 16'sh0100, 1'b0, 1'b1);
      step(1'b1, 16'shF000, 16'sh0100, 1'b1, 1'b1);
      step(1'b1, 16'shF000, 16'sh0100, 1'b0, 1'b1);
      chk("sync_last_nodump", 64'(bit_valid), 64'd0);
      for (int i = 0; i < SPS - 2; i++) step(1'b1, 16'shF000, 16'sh0100, 1'b0, 1'b1);
      step(1'b0, 16'sh0, 16'sh0, 1'b0, 1'b1);
      chk("sync_last_dump", 64'(bit_valid), 64'd1);
      chk("sync_last_soft", soft64(), -64'sh80_0000);

      // Reset mid-symbol, then an all-zero symbol
      for (int i = 0; i < 3; i++) step(1'b1, 16'sh7FFF, 16'sh7FFF, 1'b0, 1'b1);
      step(1'b1, 16'sh7FFF, 16'sh7FFF, 1'b0, 1'b0);
      chk("midrst_valid", 64'(bit_valid), 64'd0);
      chk("midrst_soft", soft64(), 64'd0);
      symbol(16'sh0, 16'sh7FFF);
      step(1'b0, 16'sh0, 16'sh0, 1'b0, 1'b1);
      chk("zero_valid", 64'(bit_valid), 64'd1);
      chk("zero_bit", 64'(bit_sig), 64'd0);
      chk("zero_soft", soft64(), 64'd0);
      chk("zero_erase", 64'(erase_sig), 64'd1);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 3) != 0),
              16'($urandom), 16'($urandom),
              ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 199) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
